// File: rtl/grf_wb_arbiter_pkg.sv
// Shared CPU definitions for the GRF write-side front end: register/data widths,
// the write-request record carried through the MDU FIFO, and the grant encoding.
package grf_wb_arbiter_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;
    localparam int NUM_REGS   = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] wa;
        logic [DATA_W-1:0]     wd;
        logic [DATA_W-1:0]     pc;
    } wr_req_t;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_PRIM = 2'd1,
        GNT_FIFO = 2'd2
    } gnt_t;

endpackage

// File: rtl/grf_wb_arbiter_if.sv
// Bus bundle between the pipeline/MDU/decode side (master) and the GRF write arbiter (slave).
interface grf_wb_arbiter_if;
    import grf_wb_arbiter_pkg::*;

    logic                  p_valid;
    logic [REG_ADDR_W-1:0] p_wa;
    logic [DATA_W-1:0]     p_wd;
    logic [DATA_W-1:0]     p_pc;

    logic                  m_valid;
    logic                  m_ready;
    logic [REG_ADDR_W-1:0] m_wa;
    logic [DATA_W-1:0]     m_wd;
    logic [DATA_W-1:0]     m_pc;

    logic                  issue_valid;
    logic [REG_ADDR_W-1:0] issue_wa;
    logic [REG_ADDR_W-1:0] q_ra1;
    logic [REG_ADDR_W-1:0] q_ra2;
    logic                  q_busy1;
    logic                  q_busy2;

    logic                  stall_req;
    logic                  grf_we;
    logic [REG_ADDR_W-1:0] grf_wa;
    logic [DATA_W-1:0]     grf_wd;
    logic [DATA_W-1:0]     grf_pc;
    logic                  err;

    modport master (
        output p_valid, p_wa, p_wd, p_pc,
        output m_valid, m_wa, m_wd, m_pc,
        input  m_ready,
        output issue_valid, issue_wa, q_ra1, q_ra2,
        input  q_busy1, q_busy2,
        input  stall_req, grf_we, grf_wa, grf_wd, grf_pc, err
    );

    modport slave (
        input  p_valid, p_wa, p_wd, p_pc,
        input  m_valid, m_wa, m_wd, m_pc,
        output m_ready,
        input  issue_valid, issue_wa, q_ra1, q_ra2,
        output q_busy1, q_busy2,
        output stall_req, grf_we, grf_wa, grf_wd, grf_pc, err
    );

endinterface

// File: rtl/grf_wb_arbiter_wb_fifo.sv
// Synchronous FIFO holding MDU write requests until they win the GRF write port.
module grf_wb_arbiter_wb_fifo
    import grf_wb_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  wr_req_t                  din,
    input  logic                     pop,
    output wr_req_t                  dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);

    wr_req_t         mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;

    // Storage carries no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    assign dout  = mem[rd_ptr];
    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/grf_wb_arbiter.sv
// GRF write-port arbiter: merges primary writebacks with buffered MDU results,
// prevents MDU starvation, and tracks in-flight MDU destinations for decode hazards.
module grf_wb_arbiter
    import grf_wb_arbiter_pkg::*;
#(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic             clk,
    input  logic             reset,
    grf_wb_arbiter_if.slave  bus
);
    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    wr_req_t          p_req;
    wr_req_t          m_req;
    wr_req_t          head;
    wr_req_t          sel_req;
    logic             push;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [AW:0]      fifo_count;
    logic [CNT_W-1:0] starve_cnt;
    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_nxt;
    logic             stall;
    logic             err_evt;
    gnt_t             gnt;

    assign p_req = '{wa: bus.p_wa, wd: bus.p_wd, pc: bus.p_pc};
    assign m_req = '{wa: bus.m_wa, wd: bus.m_wd, pc: bus.m_pc};

    // m_ready follows the registered count only; a pop this cycle does not free a slot early.
    assign bus.m_ready = (fifo_count < (AW+1)'(DEPTH));
    assign push        = bus.m_valid && !fifo_full;

    grf_wb_arbiter_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .din   (m_req),
        .pop   (pop),
        .dout  (head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign stall         = (starve_cnt >= CNT_W'(STARVE_LIMIT)) && !fifo_empty;
    assign bus.stall_req = stall;

    // Priority: forced FIFO service, then primary, then opportunistic FIFO drain.
    always_comb begin
        gnt = GNT_NONE;
        if (stall) begin
            gnt = GNT_FIFO;
        end else if (bus.p_valid) begin
            gnt = GNT_PRIM;
        end else if (!fifo_empty) begin
            gnt = GNT_FIFO;
        end
    end

    assign pop     = (gnt == GNT_FIFO);
    assign sel_req = pop ? head : p_req;

    // Set beats clear when the same register is issued and retired together.
    always_comb begin
        busy_nxt = busy;
        if (pop) begin
            busy_nxt[head.wa] = 1'b0;
        end
        if (bus.issue_valid && (bus.issue_wa != '0)) begin
            busy_nxt[bus.issue_wa] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    assign err_evt = (bus.p_valid && stall) ||
                     (bus.issue_valid && (bus.issue_wa != '0) && busy[bus.issue_wa]);

    assign bus.q_busy1 = busy[bus.q_ra1];
    assign bus.q_busy2 = busy[bus.q_ra2];

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt <= '0;
            busy       <= '0;
            bus.err    <= 1'b0;
        end else begin
            busy <= busy_nxt;
            if (err_evt) bus.err <= 1'b1;
            if (fifo_empty || pop) begin
                starve_cnt <= '0;
            end else if ((gnt == GNT_PRIM) && (starve_cnt != CNT_W'(STARVE_LIMIT))) begin
                starve_cnt <= starve_cnt + CNT_W'(1);
            end
        end
    end

    // ---- Output register stage: one-cycle latency to the GRF write port ----
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.grf_we <= 1'b0;
            bus.grf_wa <= '0;
            bus.grf_wd <= '0;
            bus.grf_pc <= '0;
        end else if (gnt != GNT_NONE) begin
            bus.grf_we <= (sel_req.wa != '0);
            bus.grf_wa <= sel_req.wa;
            bus.grf_wd <= sel_req.wd;
            bus.grf_pc <= sel_req.pc;
        end else begin
            bus.grf_we <= 1'b0;
        end
    end

endmodule
